lsu_mem_access: RTL
===================

// Module: lsu_mem_access
// PURPOSE
//   Load/store unit downstream of the opcode load/store decoder. Takes the 2-bit
//   load/store class plus funct3, effective address and store data from EX, runs one
//   data-memory transaction over a req/gnt + rvalid bus, and returns sign/zero-
//   extended load data. Stalls the pipeline while a transaction is in flight.
// PARAMETERS
//   TIMEOUT   16   max cycles in REQ+WAIT before bus-error abort (>=2)
//   TO_W      5    counter width, must hold TIMEOUT ($clog2(TIMEOUT)+1)
// PORTS
//   clk            in   1   single clock, rising edge
//   rst            in   1   synchronous, active-high reset
//   valid_lsu      in   1   EX stage holds a valid instruction
//   loadstore_lsu  in   2   00 none, 01 load, 10 store, 11 treated as none
//   funct3_lsu     in   3   [1:0] size 00 B/01 H/10 W; [2] unsigned load
//   addr_lsu       in   32  effective byte address
//   wdata_lsu      in   32  store data (rs2)
//   stall_lsu      out  1   hold pipeline
//   done_lsu       out  1   1-cycle pulse: operation finished
//   err_lsu        out  1   with done: misaligned/illegal size or timeout
//   rdata_lsu      out  32  extended load data, valid with done (0 for stores/err)
//   mem_req        out  1   bus request, held until mem_gnt
//   mem_we         out  1   1 store, 0 load
//   mem_addr       out  32  {addr[31:2],2'b00}
//   mem_be         out  4   byte enables
//   mem_wdata      out  32  lane-replicated store data
//   mem_gnt        in   1   request accepted this cycle
//   mem_rvalid     in   1   load data valid (>=1 cycle after gnt)
//   mem_rdata      in   32  load word
// BEHAVIOUR
//   Reset: state IDLE, counter 0, all outputs 0.
//   FSM IDLE->REQ->(WAIT)->DONE->IDLE; plus IDLE->ERR->IDLE.
//   IDLE: start = valid_lsu & loadstore in {01,10}. On start latch op/funct3/addr/wdata;
//     stall_lsu=1 combinationally this cycle. Misaligned (H with addr[0]=1, W with
//     addr[1:0]!=0) or size 11 -> ERR, no bus request; else -> REQ.
//   REQ: mem_req=1, mem_we/addr/be/wdata stable until gnt. On gnt: store -> DONE,
//     load -> WAIT. mem_req drops the cycle after gnt.
//   WAIT: on mem_rvalid capture lane + extend -> DONE. rvalid outside WAIT ignored.
//   Counter clears on entering REQ, +1 per cycle in REQ/WAIT; reaching TIMEOUT ->
//     ERR (mem_req deasserts, late rvalid ignored).
//   DONE/ERR: done_lsu=1 one cycle (err_lsu=1 in ERR), stall_lsu=0, -> IDLE.
//     valid_lsu not sampled in DONE/ERR; next op accepted in following IDLE cycle.
//   stall_lsu = start in IDLE, 1 in REQ/WAIT, 0 in DONE/ERR.
//   Store lanes: B be=4'b0001<<addr[1:0], wdata={4{b}}; H be=addr[1]?1100:0011,
//     wdata={2{h}}; W be=1111.
//   Load extract: B byte at addr[1:0], H half at addr[1]; sign-extend unless funct3[2].
//   Latency (0-wait bus): store gnt in REQ -> done 2 cycles after accept; load with
//     rvalid 1 cycle after gnt -> done 3 cycles after accept.
//   Reset mid-transaction: FSM -> IDLE at the edge, mem_req=0 next cycle, no done.
// TESTING
//   SW addr 0x100 data 0xDEADBEEF, gnt immediate -> mem_be=1111, mem_addr=0x100, done
//     2 cycles after accept, err=0.
//   SB addr 0x103 data 0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5.
//   LB addr 0x102, rdata 0x0080FF00 -> rdata_lsu=0xFFFFFF80; LBU -> 0x00000080;
//     LH addr 0x102 -> 0x00000080; LHU same.
//   LW addr 0x101 -> no mem_req, done+err next cycle, stall only on accept cycle.
//   Load with gnt held low TIMEOUT cycles -> done+err, mem_req drops; late rvalid ignored.
//   rst asserted in WAIT -> IDLE, no done pulse; back-to-back SW then LW both complete.

Source files
------------

// File: rtl/lsu_mem_access.sv
// Load/store unit: runs one data-memory transaction per load/store over a
// req/gnt + rvalid bus, lane-aligns store data and extends load data, and
// stalls the pipeline while the transaction is in flight.
module lsu_mem_access #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_lsu,
  input  logic [1:0]  loadstore_lsu,
  input  logic [2:0]  funct3_lsu,
  input  logic [31:0] addr_lsu,
  input  logic [31:0] wdata_lsu,
  output logic        stall_lsu,
  output logic        done_lsu,
  output logic        err_lsu,
  output logic [31:0] rdata_lsu,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] LS_LOAD  = 2'b01;
  localparam logic [1:0] LS_STORE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            is_store_q, is_store_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;

  logic            start_c;
  logic            misaligned_c;
  logic [3:0]      be_c;
  logic [31:0]     wdata_c;
  logic [31:0]     load_ext_c;
  logic [TO_W-1:0] cnt_inc_c;
  logic            timeout_c;
  logic            stall_c;

  // Request decode, alignment check and store lane placement from EX inputs.
  always_comb begin
    start_c      = valid_lsu && (loadstore_lsu == LS_LOAD || loadstore_lsu == LS_STORE);
    misaligned_c = 1'b0;
    be_c         = 4'b1111;
    wdata_c      = wdata_lsu;
    case (funct3_lsu[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr_lsu[1:0];
        wdata_c = {4{wdata_lsu[7:0]}};
      end
      2'b01: begin
        misaligned_c = addr_lsu[0];
        be_c         = addr_lsu[1] ? 4'b1100 : 4'b0011;
        wdata_c      = {2{wdata_lsu[15:0]}};
      end
      2'b10: misaligned_c = (addr_lsu[1:0] != 2'b00);
      default: misaligned_c = 1'b1;
    endcase
  end

  // Load lane extraction with sign or zero extension.
  always_comb begin
    load_ext_c = mem_rdata;
    case (funct3_q[1:0])
      2'b00: begin
        logic [7:0] b;
        case (addr_lo_q)
          2'b00:   b = mem_rdata[7:0];
          2'b01:   b = mem_rdata[15:8];
          2'b10:   b = mem_rdata[23:16];
          default: b = mem_rdata[31:24];
        endcase
        load_ext_c = funct3_q[2] ? {24'h0, b} : {{24{b[7]}}, b};
      end
      2'b01: begin
        logic [15:0] h;
        h = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_ext_c = funct3_q[2] ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: load_ext_c = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rdata_d     = 32'h0;
    stall_c     = 1'b0;
    cnt_inc_c   = cnt_q + TO_W'(1);
    timeout_c   = (cnt_inc_c >= TO_W'(TIMEOUT));

    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          stall_c     = 1'b1;
          is_store_d  = (loadstore_lsu == LS_STORE);
          funct3_d    = funct3_lsu;
          addr_lo_d   = addr_lsu[1:0];
          mem_we_d    = (loadstore_lsu == LS_STORE);
          mem_addr_d  = {addr_lsu[31:2], 2'b00};
          mem_be_d    = be_c;
          mem_wdata_d = wdata_c;
          if (misaligned_c) begin
            state_d = S_ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d   = S_REQ;
            mem_req_d = 1'b1;
            cnt_d     = '0;
          end
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        cnt_d   = cnt_inc_c;
        if (mem_gnt) begin
          if (is_store_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end else if (timeout_c) begin
          state_d = S_ERR;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_inc_c;
        if (mem_rvalid) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          rdata_d = load_ext_c;
        end else if (timeout_c) begin
          state_d = S_ERR;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign stall_lsu = stall_c;
  assign done_lsu  = done_q;
  assign err_lsu   = err_q;
  assign rdata_lsu = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule
